// File: rtl/conv_result_reader_if.sv
// Result stream interface for conv_result_reader.
// Purpose : carries the valid/ready word stream from the reader to its consumer.
// Signals : m_valid - word valid (reader -> consumer)
//           m_ready - consumer accept (consumer -> reader)
//           m_data  - result word (reader -> consumer)
//           m_last  - final word of a read-out (reader -> consumer)
// Modports: master (reader side), slave (consumer side).
interface conv_result_reader_if #(
  parameter int unsigned DATA_W = 16
) ();
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/conv_result_reader.sv
// conv_result_reader
// Purpose : after the accelerator's busy flag falls, reads rd_len words from the result SRAM
//           (addresses 0..rd_len-1) and streams them out over a valid/ready interface through a
//           2-entry skid FIFO, flagging the final word and pulsing rd_done when it is accepted.
// Ports   : clk, reset_b           - clock, asynchronous active-low reset
//           dut_busy, rd_len       - accelerator busy flag (1->0 triggers), words to read
//           rdr_sram_read_address  - registered SRAM read address
//           sram_rdr_read_data     - SRAM data for the previous cycle's address
//           m_if (master)          - m_valid / m_ready / m_data / m_last result stream
//           rdr_busy, rd_done      - read-out in progress, one-cycle completion pulse
//           rd_overrun             - sticky: dut_busy rose during a read-out
//           checksum               - XOR of accepted words (only with RESULT_CHECKSUM_EN)
// Build option: define RESULT_CHECKSUM_EN to add the checksum output and its accumulator.
module conv_result_reader #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 16
) (
  input  logic                 clk,
  input  logic                 reset_b,
  input  logic                 dut_busy,
  input  logic [ADDR_W-1:0]    rd_len,
  output logic [ADDR_W-1:0]    rdr_sram_read_address,
  input  logic [DATA_W-1:0]    sram_rdr_read_data,
  conv_result_reader_if.master m_if,
  output logic                 rdr_busy,
  output logic                 rd_done,
`ifdef RESULT_CHECKSUM_EN
  output logic [DATA_W-1:0]    checksum,
`endif
  output logic                 rd_overrun
);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e            state_q, state_d;
  logic              busy_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] last_addr_q;
  logic              inflight_q, inflight_last_q;
  logic [DATA_W-1:0] fifo_data_q [2];
  logic [1:0]        fifo_last_q;
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        cnt_q;
  logic              rd_done_q;
  logic              overrun_q;

  logic              trigger, busy_rise;
  logic              fifo_valid, pop, push, head_last, last_hs;
  logic              issue, issue_last;
  logic [1:0]        occ_next;

  assign trigger    = busy_q & ~dut_busy & (state_q == StIdle);
  assign busy_rise  = ~busy_q & dut_busy;
  assign fifo_valid = (cnt_q != 2'd0);
  assign pop        = fifo_valid & m_if.m_ready;
  assign push       = inflight_q;
  assign head_last  = fifo_last_q[rd_ptr_q];
  assign last_hs    = pop & head_last;
  assign issue_last = (addr_q == last_addr_q);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    // Occupancy once this cycle's pop and the returning read land; a new read is only safe if a
    // slot is still guaranteed for it next cycle even if the consumer stalls.
    occ_next = cnt_q - 2'(pop) + 2'(inflight_q);
    issue    = (state_q == StIssue) && (occ_next < 2'd2);
    unique case (state_q)
      StIdle: begin
        if (trigger && (rd_len != '0)) state_d = StIssue;
      end
      StIssue: begin
        if (issue) begin
          if (issue_last) state_d = StDrain;
          else            addr_d  = addr_q + ADDR_W'(1);
        end
      end
      StDrain: begin
        if (last_hs) begin
          state_d = StIdle;
          addr_d  = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q         <= StIdle;
      busy_q          <= 1'b0;
      addr_q          <= '0;
      last_addr_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      fifo_data_q[0]  <= '0;
      fifo_data_q[1]  <= '0;
      fifo_last_q     <= '0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      cnt_q           <= '0;
      rd_done_q       <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      busy_q          <= dut_busy;
      addr_q          <= addr_d;
      inflight_q      <= issue;
      inflight_last_q <= issue & issue_last;
      if (trigger && (rd_len != '0)) last_addr_q <= rd_len - ADDR_W'(1);
      if (push) begin
        fifo_data_q[wr_ptr_q] <= sram_rdr_read_data;
        fifo_last_q[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q     <= cnt_q + 2'(push) - 2'(pop);
      rd_done_q <= (trigger && (rd_len == '0)) || ((state_q == StDrain) && last_hs);
      if (trigger)                              overrun_q <= 1'b0;
      else if (busy_rise && (state_q != StIdle)) overrun_q <= 1'b1;
    end
  end

`ifdef RESULT_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b)     checksum_q <= '0;
    else if (trigger) checksum_q <= '0;
    else if (pop)     checksum_q <= checksum_q ^ fifo_data_q[rd_ptr_q];
  end

  assign checksum = checksum_q;
`endif

  assign rdr_sram_read_address = addr_q;
  assign m_if.m_valid          = fifo_valid;
  assign m_if.m_data           = fifo_data_q[rd_ptr_q];
  assign m_if.m_last           = fifo_valid & head_last;
  assign rdr_busy              = (state_q != StIdle);
  assign rd_done               = rd_done_q;
  assign rd_overrun            = overrun_q;

endmodule
